// File: rtl/or_reduce_scheduler.sv
// or_reduce_scheduler: multi-cycle OR reduction of a WIDTH-bit operand.
// One registered OR layer is reused in one of two schedules: a balanced
// tree (log2(WIDTH) steps) or a linear chain (WIDTH-1 steps). The result
// and the number of steps taken are presented over a valid/ready handshake.
module or_reduce_scheduler #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    output logic             out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CW-1:0]    cycles
);

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;      // working operand
    logic             m_q, m_d;      // latched schedule: 0 = tree, 1 = chain
    logic [CW-1:0]    s_q, s_d;      // steps completed so far
    logic [CW-1:0]    t_q, t_d;      // steps required for this operation

    logic [CW-1:0]    s_inc;
    logic [WIDTH-1:0] tree_r;
    logic [WIDTH-1:0] chain_r;

    // Candidate next values of R for one tree step and one chain step.
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        s_inc  = s_q + CW'(1);
        tree_r = '0;
        for (int i = 0; i < WIDTH / 2; i++) begin
            // Live width halves every step; pairs beyond it collapse to 0.
            if (i < ((WIDTH >> s_q) / 2)) begin
                tree_r[i] = r_q[2*i] | r_q[2*i+1];
            end
        end
        // Chain folds the next untouched bit into R[0]; S+1 never exceeds WIDTH-1.
        chain_r    = r_q;
        chain_r[0] = r_q[0] | r_q[s_inc];
    end

    // Next-state and datapath update for the IDLE/REDUCE/DONE controller.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        m_d     = m_q;
        s_d     = s_q;
        t_d     = t_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    r_d     = in_data;
                    m_d     = mode;
                    s_d     = '0;
                    t_d     = mode ? CW'(WIDTH - 1) : CW'(CW);
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                r_d = m_q ? chain_r : tree_r;
                s_d = s_inc;
                if (s_inc == t_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    // NOTE: R is cleared on reset too, so an aborted operation leaves no stale operand behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            m_q     <= 1'b0;
            s_q     <= '0;
            t_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            r_q     <= r_d;
            m_q     <= m_d;
            s_q     <= s_d;
            t_q     <= t_d;
        end
    end

    // Outputs decoded from registered state; only in_ready also sees rst_n.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = (state_q == DONE) ? r_q[0] : 1'b0;
    assign cycles    = (state_q == DONE) ? t_q : '0;

endmodule

// File: tb/tb_or_reduce_scheduler.sv
// Directed bench for or_reduce_scheduler at WIDTH=8.
module tb_or_reduce_scheduler;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic             out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CW-1:0]    cycles;

    int checks = 0;
    int errors = 0;

    or_reduce_scheduler #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; sampling happens 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_data"},  32'(out_data),  32'd0);
        check({tag, ".cycles"},    32'(cycles),    32'd0);
    endtask

    task automatic check_result(input string tag, input logic exp_data, input int exp_cycles);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".out_data"},  32'(out_data),  32'(exp_data));
        check({tag, ".cycles"},    32'(cycles),    32'(exp_cycles));
        check({tag, ".busy"},      32'(busy),      32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_data"},  32'(out_data),  32'd0);
        check({tag, ".cycles"},    32'(cycles),    32'd0);
    endtask

    // Present one operand for a single edge (E0) and withdraw it.
    task automatic accept(input logic [WIDTH-1:0] data, input logic m);
        in_data  = data;
        mode     = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        check("accept.busy",     32'(busy),     32'd1);
        check("accept.in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;

        // Reset state: everything low, including in_ready.
        #3;
        check_all_zero("reset");
        tick();
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        // Tree, operand 0: result at E3, handshake at E4.
        accept(8'h00, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            tick();
            check("tree0.early_valid", 32'(out_valid), 32'd0);
            check("tree0.busy",        32'(busy),      32'd1);
        end
        tick();
        check_result("tree0.E3", 1'b0, 3);
        tick();
        check_idle("tree0.E4");

        // Tree, top bit set.
        accept(8'h80, 1'b0);
        tick();
        tick();
        check("tree80.E2_valid", 32'(out_valid), 32'd0);
        tick();
        check_result("tree80.E3", 1'b1, 3);
        tick();
        check_idle("tree80.E4");

        // Chain, top bit set: R[0] only picks it up on the last step.
        accept(8'h80, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("chain80.early_valid", 32'(out_valid),     32'd0);
            check("chain80.r0_low",      32'(dut.r_q[0]),    32'd0);
        end
        tick();
        check_result("chain80.E7", 1'b1, 7);
        tick();
        check_idle("chain80.E8");

        // Chain, bottom bit set, with 5 cycles of backpressure.
        out_ready = 1'b0;
        accept(8'h01, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
        end
        check("chain01.E6_valid", 32'(out_valid), 32'd0);
        tick();
        check_result("chain01.E7", 1'b1, 7);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_result("chain01.stall", 1'b1, 7);
            check("chain01.stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check_idle("chain01.handshake");

        // Inputs offered while busy are ignored.
        accept(8'h00, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int k = 1; k <= 2; k++) begin
            mode = ~mode;
            tick();
            check("ignore.in_ready", 32'(in_ready),  32'd0);
            check("ignore.valid",    32'(out_valid), 32'd0);
        end
        mode = ~mode;
        tick();
        check_result("ignore.E3", 1'b0, 3);
        mode = ~mode;
        tick();
        // Handshake edge: back in IDLE but the pending operand not yet taken.
        check("ignore.E4_busy",     32'(busy),      32'd0);
        check("ignore.E4_in_ready", 32'(in_ready),  32'd1);
        check("ignore.E4_valid",    32'(out_valid), 32'd0);
        mode = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        check("second.accepted", 32'(busy), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            tick();
        end
        check("second.E6_valid", 32'(out_valid), 32'd0);
        tick();
        check_result("second.E7", 1'b1, 7);
        tick();
        check_idle("second.E8");

        // Reset in the middle of a chain operation.
        accept(8'h80, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all_zero("midreset_hold");
        end
        rst_n = 1'b1;
        #1;
        check_idle("after_release");
        tick();
        check_idle("after_release_cycle");

        // Fresh tree operation after reset.
        accept(8'h10, 1'b0);
        tick();
        tick();
        check("tree10.E2_valid", 32'(out_valid), 32'd0);
        tick();
        check_result("tree10.E3", 1'b1, 3);
        tick();
        check_idle("tree10.E4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_reduce_scheduler.md
# or_reduce_scheduler

Multi-cycle OR-reduction controller. It accepts a WIDTH-bit operand over a valid/ready handshake and reduces it to one bit by reusing a single registered OR layer over several cycles. The layer runs in one of two schedules: balanced tree (log2(WIDTH) steps) or linear chain (WIDTH-1 steps). It sits in front of pattern-optimisation experiments as the sequenced reference for cascaded versus tree OR structures. It also reports the step count per operation.

## Interface
- WIDTH, 8, operand width; power of two, 2..64
- CW, $clog2(WIDTH), width of the step-count output (derived, not overridden)
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_data  input  WIDTH  operand
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- mode  input  1  schedule select, sampled with operand: 0 = tree, 1 = chain
- out_data  output  1  OR of all operand bits
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- busy  output  1  high in REDUCE or DONE
- cycles  output  CW  number of reduction steps used for the current result

## Operation
- Storage: WIDTH-bit register R, latched mode bit M, step counter S (CW bits), target count T.
- FSM states: IDLE, REDUCE, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: R <= in_data, M <= mode, S <= 0, T <= (mode ? WIDTH-1 : log2(WIDTH)), go to REDUCE.
- REDUCE, one step per cycle:
  - Tree step (M=0), with width w = WIDTH >> S: R[i] <= R[2i] | R[2i+1] for i < w/2. Bits i >= w/2 are cleared to 0.
  - Chain step (M=1): R[0] <= R[0] | R[S+1]. All other bits are unchanged.
  - S <= S+1. When S+1 == T, go to DONE.
- DONE:
  - out_valid = 1, out_data = R[0], cycles = T.
  - All three are held stable until out_valid && out_ready, then go to IDLE.
- in_valid outside IDLE is ignored; in_ready = 0 there.
- mode changes after acceptance have no effect on the operation in flight.
- There is no combinational path from in_data or mode to out_data.
- out_ready has no effect outside DONE.
- Reset (asynchronous, any state, including mid-REDUCE):
  - State goes to IDLE; R, M, S and T are cleared; the in-flight operation is discarded without any output.
  - out_valid = 0, out_data = 0, cycles = 0, busy = 0.
  - in_ready is forced to 0 while rst_n is low, and is 1 from the first cycle after release.
- Outputs outside DONE: out_data = 0, out_valid = 0, cycles = 0.

## Timing
- Acceptance edge is E0. Reduction steps occur at edges E1..ET. out_valid is high from ET to the handshake edge.
- Tree, WIDTH=8: T=3, so the result is visible 3 cycles after acceptance.
- Chain, WIDTH=8: T=7.
- With out_ready held high:
  - The handshake occurs at edge ET+1.
  - in_ready rises in the following cycle.
  - The next acceptance can occur at ET+2, giving a minimum period of T+2 cycles.
- Backpressure: out_valid, out_data and cycles stay constant while out_ready = 0, for any number of cycles.
- WIDTH=2: tree and chain both take T=1.
- All outputs except in_ready are registered or decoded from registered state only.
  - in_ready = (state == IDLE) && rst_n.

## Test plan
- Tree, zero operand: WIDTH=8, mode=0, in_data=8'h00 accepted at E0 -> out_valid at E3, out_data=0, cycles=3, busy high E0..E4 with out_ready=1.
- Tree, top bit: mode=0, in_data=8'h80 -> out_data=1 at E3, cycles=3.
- Chain, top bit: mode=1, in_data=8'h80 -> out_valid first seen at E7, out_data=1, cycles=7, R[0] goes 1 only at E7.
- Chain, bottom bit with backpressure: mode=1, in_data=8'h01, out_ready=0 for 5 cycles after out_valid -> out_data=1, cycles=7 held stable; handshake on the first cycle out_ready=1, then in_ready=1 the next cycle.
- Busy-time inputs ignored: in_valid=1 with in_data=8'hFF and mode toggling during REDUCE of an 8'h00 tree operation -> result 0, cycles=3; second operand taken only after return to IDLE.
- Reset mid-operation: assert rst_n=0 at E2 of a chain operation with 8'h80 -> out_valid never rises, all outputs 0 during reset. After release: in_ready=1; a new tree operation with 8'h10 gives out_data=1, cycles=3.
